// File: rtl/sw_cond_pkg.sv
// Shared definitions for the switch conditioner: debounce FSM state encoding,
// default debounce window and board clock frequency.
package sw_cond_pkg;

  localparam int CLK_HZ                  = 50_000_000;
  // 10 ms at CLK_HZ
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500_000;

  // Bit 1 of the encoding is the currently accepted (stable) level, so the
  // debounced output can be taken straight from the state register.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b11,
    PEND_LO   = 2'b10
  } deb_state_e;

endpackage

// File: rtl/sw_conditioner_debounce_cell.sv
// debounce_cell: one switch bit -- 2-flop synchronizer, 4-state debounce FSM
// and its hold counter. Emits single-cycle commit strobes (combinational,
// valid for the edge on which the stable level changes).
module debounce_cell
  import sw_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State register: synchronizer, FSM state and hold counter.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values; blocking here
      // would collapse sync1/sync2 into a single stage.
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: leave STABLE on a difference, abort PEND on a return,
  // commit once the new level has held for the full window.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs -- no latches.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE_LO: if (sync2_q) begin
        state_d = PEND_HI;
        cnt_d   = CNT_ONE;
      end
      PEND_HI: begin
        if (!sync2_q) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: if (!sync2_q) begin
        state_d = PEND_LO;
        cnt_d   = CNT_ONE;
      end
      PEND_LO: begin
        if (sync2_q) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: stable level is a state bit; commit strobes flag the edge.
  always_comb begin
    stable_o = state_q[1];
    rise_o   = (state_q == PEND_HI) && (state_d == STABLE_HI);
    fall_o   = (state_q == PEND_LO) && (state_d == STABLE_LO);
  end

endmodule

// File: rtl/sw_conditioner.sv
// sw_conditioner: WIDTH debounced DIP-switch bits ([7:4] swy, [3:0] swx),
// a merged change pulse and a power-up valid flag.
// Optional build macro SW_CONDITIONER_EDGE_EN adds per-bit sw_rise/sw_fall.
module sw_conditioner
  import sw_cond_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             real_rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_changed,
  output logic             sw_valid
`ifdef SW_CONDITIONER_EDGE_EN
  ,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
`endif
);

  localparam int                VCNT_W    = $clog2(DEBOUNCE_CYCLES + 2);
  localparam logic [VCNT_W-1:0] VCNT_LAST = VCNT_W'(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0]  rise_vec, fall_vec;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  logic              valid_q, valid_d;
  logic              changed_q, changed_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk     (clk),
      .rst_i   (real_rst),
      .raw_i   (sw_raw[i]),
      .stable_o(sw_stable[i]),
      .rise_o  (rise_vec[i]),
      .fall_o  (fall_vec[i])
    );
  end

  // Valid counter saturates so sw_valid rises DEBOUNCE_CYCLES+2 edges after
  // release. Change pulses are gated by the registered flag, so a commit on
  // the same edge that raises sw_valid (power-up state) is not announced.
  always_comb begin
    vcnt_d    = (vcnt_q == VCNT_LAST) ? vcnt_q : vcnt_q + VCNT_W'(1);
    valid_d   = valid_q | (vcnt_q == VCNT_LAST);
    changed_d = valid_q & (|(rise_vec | fall_vec));
  end

  // Valid flag and single merged change pulse, aligned with sw_stable.
  always_ff @(posedge clk) begin
    if (real_rst) begin
      vcnt_q    <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      vcnt_q    <= vcnt_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
    end
  end

  assign sw_valid   = valid_q;
  assign sw_changed = changed_q;

`ifdef SW_CONDITIONER_EDGE_EN
  logic [WIDTH-1:0] rise_q, fall_q;

  // Per-bit edge pulses, under the same suppression as sw_changed.
  always_ff @(posedge clk) begin
    if (real_rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= valid_q ? rise_vec : '0;
      fall_q <= valid_q ? fall_vec : '0;
    end
  end

  assign sw_rise = rise_q;
  assign sw_fall = fall_q;
`else
  // Edge outputs not built: commit strobes only feed sw_changed.
`endif

endmodule

// File: tb/tb_sw_conditioner.sv
// Scoreboard bench for sw_conditioner (WIDTH=8, DEBOUNCE_CYCLES=4).
// Stimulus pushes each expected commit; a negedge monitor pops on sw_changed.
module tb_sw_conditioner;

  localparam int WIDTH = 8;
  localparam int DEB   = 4;

  logic             clk = 1'b0;
  logic             real_rst = 1'b1;
  logic [WIDTH-1:0] sw_raw = '0;
  logic [WIDTH-1:0] sw_stable;
  logic             sw_changed;
  logic             sw_valid;
`ifdef SW_CONDITIONER_EDGE_EN
  logic [WIDTH-1:0] sw_rise, sw_fall;
`endif

  sw_conditioner #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .real_rst  (real_rst),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .sw_changed(sw_changed),
    .sw_valid  (sw_valid)
`ifdef SW_CONDITIONER_EDGE_EN
    ,
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] stable;
    logic [7:0] rise;
    logic [7:0] fall;
    int         edge_no;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected commit: stable value, edge strobes, and the edge it lands on
  // (input sampled on the coming edge k = cyc+1, committed after k+5).
  task automatic push(input logic [7:0] s, input logic [7:0] r, input logic [7:0] f);
    exp_t e;
    e.stable  = s;
    e.rise    = r;
    e.fall    = f;
    e.edge_no = cyc + 1 + DEB + 1;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every sw_changed pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (sw_changed) begin
      if (sb_q.size() == 0) begin
        check("unexpected_changed", 32'(sw_changed), 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check("commit_stable", 32'(sw_stable), 32'(mon_e.stable));
        check("commit_edge", 32'(cyc), 32'(mon_e.edge_no));
`ifdef SW_CONDITIONER_EDGE_EN
        check("commit_rise", 32'(sw_rise), 32'(mon_e.rise));
        check("commit_fall", 32'(sw_fall), 32'(mon_e.fall));
`endif
      end
    end
`ifdef SW_CONDITIONER_EDGE_EN
    else if ((sw_rise | sw_fall) != '0) begin
      check("edge_without_changed", 32'(sw_rise | sw_fall), 32'h0);
    end
`endif
  end

  initial begin
    // Reset state
    tick(3);
    check("reset_stable", 32'(sw_stable), 32'h00);
    check("reset_changed", 32'(sw_changed), 32'h0);
    check("reset_valid", 32'(sw_valid), 32'h0);

    // Valid rises exactly 6 edges after release, inputs idle low
    real_rst = 1'b0;
    tick(5);
    check("valid_before_window", 32'(sw_valid), 32'h0);
    tick(1);
    check("valid_after_window", 32'(sw_valid), 32'h1);
    check("idle_stable", 32'(sw_stable), 32'h00);

    // 3-cycle glitch on bit 0: one sample short of a commit
    sw_raw = 8'h01;
    tick(3);
    sw_raw = 8'h00;
    tick(8);
    check("glitch_stable", 32'(sw_stable), 32'h00);

    // Clean multi-bit step 00->35: one pulse, no early change
    sw_raw = 8'h35;
    push(8'h35, 8'h35, 8'h00);
    tick(5);
    check("step_no_early", 32'(sw_stable), 32'h00);
    tick(1);
    check("step_commit", 32'(sw_stable), 32'h35);
    tick(3);

    // Return to 00
    sw_raw = 8'h00;
    push(8'h00, 8'h00, 8'h35);
    tick(8);
    check("fall_commit", 32'(sw_stable), 32'h00);

    // Bit 0 then bit 7 one edge later: two separate pulses
    sw_raw = 8'h01;
    push(8'h01, 8'h01, 8'h00);
    tick(1);
    sw_raw = 8'h81;
    push(8'h81, 8'h80, 8'h00);
    tick(4);
    check("stagger_none", 32'(sw_stable), 32'h00);
    tick(1);
    check("stagger_bit0", 32'(sw_stable), 32'h01);
    tick(1);
    check("stagger_bit7", 32'(sw_stable), 32'h81);
    tick(3);

    // Bit 1 high for exactly 4 samples: commits high, then commits low
    sw_raw = 8'h83;
    push(8'h83, 8'h02, 8'h00);
    tick(4);
    sw_raw = 8'h81;
    push(8'h81, 8'h00, 8'h02);
    tick(10);
    check("min_pulse_final", 32'(sw_stable), 32'h81);

    // All high, reset for 2 edges while pending bits are at count 2
    sw_raw = 8'hFF;
    tick(4);
    real_rst = 1'b1;
    tick(1);
    check("midrst_stable_1", 32'(sw_stable), 32'h00);
    check("midrst_valid_1", 32'(sw_valid), 32'h0);
    tick(1);
    check("midrst_stable_2", 32'(sw_stable), 32'h00);
    check("midrst_changed_2", 32'(sw_changed), 32'h0);
    real_rst = 1'b0;
    tick(5);
    check("postrst_stable_early", 32'(sw_stable), 32'h00);
    check("postrst_valid_early", 32'(sw_valid), 32'h0);
    tick(1);
    check("postrst_commit", 32'(sw_stable), 32'hFF);
    check("postrst_valid", 32'(sw_valid), 32'h1);
    check("postrst_changed_suppressed", 32'(sw_changed), 32'h0);
    tick(3);

    // After valid, changes are announced again
    sw_raw = 8'h00;
    push(8'h00, 8'h00, 8'hFF);
    tick(8);
    check("final_stable", 32'(sw_stable), 32'h00);

    // Bounded drain of outstanding expected commits
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick(1);
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_conditioner.md
SW_CONDITIONER -- requirements
Module: sw_conditioner

Interface
REQ-001 Parameter WIDTH, default 8: number of switch bits conditioned.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: clk cycles an input must hold a new level before it is accepted (10 ms at 50 MHz); legal range 2 to 2^24.
REQ-003 clk  in  1  system clock, 50 MHz board oscillator.
REQ-004 real_rst  in  1  reset; synchronous to clk, active-high.
REQ-005 sw_raw  in  WIDTH  asynchronous DIP-switch levels; [7:4] = swy, [3:0] = swx.
REQ-006 sw_stable  out  WIDTH  debounced switch levels, registered.
REQ-007 sw_changed  out  1  one-cycle pulse when any sw_stable bit updates.
REQ-008 sw_valid  out  1  high once a full debounce window has elapsed since reset.

Function
REQ-009 Each sw_raw bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-010 Each bit SHALL run an independent 4-state FSM: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-011 STABLE_x -> PEND_y SHALL occur on the edge where sync2 differs from the current stable level; the bit's counter loads 1.
REQ-012 In PEND_y, if sync2 returns to the stable level, the FSM SHALL return to STABLE_x and clear its counter on that edge; a glitch never reaches sw_stable.
REQ-013 In PEND_y, when the counter equals DEBOUNCE_CYCLES-1 and sync2 still differs, the FSM SHALL move to STABLE_y, update the sw_stable bit and clear the counter on the same edge.
REQ-014 Latency: a clean sw_raw step sampled at edge k SHALL appear on sw_stable after edge k+1+DEBOUNCE_CYCLES, with no earlier change.
REQ-015 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); it SHALL never wrap. Hold at DEBOUNCE_CYCLES-1 is unreachable by construction.
REQ-016 sw_changed SHALL assert for exactly one cycle, aligned with the sw_stable update. If several bits commit on the same edge, it SHALL produce one pulse, not one per bit.
REQ-017 sw_valid SHALL be driven by a global counter that saturates after DEBOUNCE_CYCLES+2 cycles from reset release, then stays high until the next reset.
REQ-018 sw_changed SHALL be suppressed (held 0) while sw_valid is low. sw_stable still tracks during that window.

Reset
REQ-019 While real_rst is high, on every clk edge: sync flops = 0, all FSMs = STABLE_LO, all counters = 0, sw_stable = 0, sw_changed = 0, sw_valid = 0, valid counter = 0.
REQ-020 Reset asserted mid-debounce SHALL discard the pending transition; no commit occurs on the reset edge.
REQ-021 Switches held high through reset SHALL commit DEBOUNCE_CYCLES+2 edges after reset release.

Configuration
REQ-022 Macro SW_CONDITIONER_EDGE_EN: when defined, the block adds outputs sw_rise [WIDTH] and sw_fall [WIDTH].
- sw_rise and sw_fall are one-cycle per-bit pulses, coincident with the STABLE_LO->STABLE_HI and STABLE_HI->STABLE_LO commits.
- They obey the REQ-018 suppression and reset to 0.
REQ-023 When SW_CONDITIONER_EDGE_EN is undefined, those ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-024 A shared package sw_cond_pkg SHALL hold:
- the FSM state enum (2-bit encoding: STABLE_LO=00, PEND_HI=01, STABLE_HI=11, PEND_LO=10);
- default DEBOUNCE_CYCLES;
- a CLK_HZ constant of 50_000_000.
REQ-025 The per-bit synchronizer, FSM and counter SHALL be a sub-module debounce_cell, instantiated WIDTH times via generate. sw_conditioner adds the valid counter and the changed/edge merge.

Verification
All scenarios use DEBOUNCE_CYCLES=4, WIDTH=8.
REQ-026 Reset release, sw_raw=8'h00 held -> sw_valid rises exactly 6 cycles after release; sw_stable=8'h00; sw_changed never pulses.
REQ-027 After sw_valid, sw_raw 8'h00->8'h35 at edge k -> sw_stable=8'h35 after edge k+5; one sw_changed pulse; with EDGE_EN, sw_rise=8'h35 for one cycle.
REQ-028 A 3-cycle high glitch on sw_raw[0] -> sw_stable unchanged; no sw_changed; FSM back in STABLE_LO.
REQ-029 Bit 0 rises at edge k and bit 7 at edge k+1 -> two separate sw_changed pulses, after edges k+5 and k+6.
REQ-030 sw_raw=8'hFF, real_rst pulsed 2 cycles while PEND_HI count=2 -> sw_stable=8'h00 during and after reset; commits to 8'hFF 6 edges after release; sw_changed suppressed until sw_valid.
